cva6_hpdcache_fence_ctrl: RTL and testbench

//  Sequences FENCE and FENCE.I for the HPDcache write-through data cache subsystem.
//  - Drains the store buffer and the cache write buffer.
//  - Optionally flushes/invalidates the D$ (per DcacheFlushOnFence / DcacheInvalidateOnFlush).
//  - Issues the I$ flush for FENCE.I.

---
 rtl/cva6_hpdcache_fence_ctrl_if.sv | 31 +++
 rtl/cva6_hpdcache_fence_ctrl.sv | 100 ++++++++++
 tb/tb_cva6_hpdcache_fence_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cva6_hpdcache_fence_ctrl_if.sv
// Control pins between commit, the fence sequencer and the HPDcache subsystem.
// "master" drives requests, buffer status and acks; "slave" is the sequencer.
interface cva6_hpdcache_fence_ctrl_if;
   logic fence_valid_i;
   logic fence_kind_i;
   logic fence_ready_o;
   logic fence_done_o;
   logic halt_o;
   logic stbuf_empty_i;
   logic wbuf_empty_i;
   logic dcache_flush_o;
   logic dcache_flush_ack_i;
   logic dcache_inval_o;
   logic dcache_inval_ack_i;
   logic icache_flush_o;
   logic drain_timeout_o;

   modport master (
      output fence_valid_i, fence_kind_i, stbuf_empty_i, wbuf_empty_i,
             dcache_flush_ack_i, dcache_inval_ack_i,
      input  fence_ready_o, fence_done_o, halt_o, dcache_flush_o, dcache_inval_o,
             icache_flush_o, drain_timeout_o
   );

   modport slave (
      input  fence_valid_i, fence_kind_i, stbuf_empty_i, wbuf_empty_i,
             dcache_flush_ack_i, dcache_inval_ack_i,
      output fence_ready_o, fence_done_o, halt_o, dcache_flush_o, dcache_inval_o,
             icache_flush_o, drain_timeout_o
   );
endinterface

// File: rtl/cva6_hpdcache_fence_ctrl.sv
// FENCE / FENCE.I sequencer: drain store/write buffers, optional D$ flush and
// invalidate, I$ flush for FENCE.I, then a one-cycle completion pulse.
module cva6_hpdcache_fence_ctrl #(
   parameter bit          FlushOnFence      = 1'b0,
   parameter bit          InvalidateOnFlush = 1'b0,
   parameter int unsigned DrainTimeout      = 1024,
   parameter int unsigned CntW = (DrainTimeout > 0) ? $clog2(DrainTimeout + 1) : 1
) (
   input logic                           clk_i,
   input logic                           rst_i,
   cva6_hpdcache_fence_ctrl_if.slave     bus
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StDrain   = 3'd1;
   localparam logic [2:0] StFlush   = 3'd2;
   localparam logic [2:0] StInval   = 3'd3;
   localparam logic [2:0] StIcflush = 3'd4;
   localparam logic [2:0] StDone    = 3'd5;

   localparam logic [CntW-1:0] SatCnt = CntW'(DrainTimeout);
   localparam logic [CntW-1:0] TmoCnt = CntW'((DrainTimeout > 0) ? DrainTimeout - 1 : 0);

   logic [2:0]      state_q, state_d;
   logic            kind_q, kind_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            tmo_q, tmo_d;
   logic            drained;
   logic            need_flush;

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      drained    = bus.stbuf_empty_i & bus.wbuf_empty_i;
      need_flush = FlushOnFence | kind_q;
      cnt_inc    = (cnt_q == SatCnt) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         StIdle: begin
            if (bus.fence_valid_i) begin
               kind_d  = bus.fence_kind_i;
               cnt_d   = '0;
               tmo_d   = 1'b0;
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (drained) begin
               state_d = need_flush ? StFlush : (kind_q ? StIcflush : StDone);
            end else begin
               cnt_d = cnt_inc;
               // Flag is sticky; the sequence keeps waiting for the drain.
               if ((DrainTimeout > 0) && (cnt_inc >= TmoCnt)) begin
                  tmo_d = 1'b1;
               end
            end
         end
         StFlush: begin
            if (bus.dcache_flush_ack_i) begin
               state_d = InvalidateOnFlush ? StInval : (kind_q ? StIcflush : StDone);
            end
         end
         StInval: begin
            if (bus.dcache_inval_ack_i) begin
               state_d = kind_q ? StIcflush : StDone;
            end
         end
         StIcflush: state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         kind_q  <= 1'b0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      bus.fence_ready_o   = (state_q == StIdle);
      bus.halt_o          = (state_q != StIdle);
      bus.fence_done_o    = (state_q == StDone);
      bus.dcache_flush_o  = (state_q == StFlush);
      bus.dcache_inval_o  = (state_q == StInval);
      bus.icache_flush_o  = (state_q == StIcflush);
      bus.drain_timeout_o = tmo_q;
   end

endmodule

// File: tb/tb_cva6_hpdcache_fence_ctrl.sv
// Scoreboard bench: stimulus queues expected output snapshots per cycle, a
// negedge monitor pops and compares whenever the DUT shows activity or a probe.
module tb_cva6_hpdcache_fence_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic valid = 1'b0, kind = 1'b0, stbuf = 1'b1, wbuf = 1'b1;
   logic flush_ack = 1'b0, inval_ack = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cva6_hpdcache_fence_ctrl_if if_d ();
   cva6_hpdcache_fence_ctrl_if if_p ();

   assign if_d.fence_valid_i = valid;      assign if_p.fence_valid_i = valid;
   assign if_d.fence_kind_i = kind;        assign if_p.fence_kind_i = kind;
   assign if_d.stbuf_empty_i = stbuf;      assign if_p.stbuf_empty_i = stbuf;
   assign if_d.wbuf_empty_i = wbuf;        assign if_p.wbuf_empty_i = wbuf;
   assign if_d.dcache_flush_ack_i = flush_ack; assign if_p.dcache_flush_ack_i = flush_ack;
   assign if_d.dcache_inval_ack_i = inval_ack; assign if_p.dcache_inval_ack_i = inval_ack;

   cva6_hpdcache_fence_ctrl dut_d (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_d)
   );

   cva6_hpdcache_fence_ctrl #(
      .FlushOnFence      (1'b0),
      .InvalidateOnFlush (1'b1),
      .DrainTimeout      (8)
   ) dut_p (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_p)
   );

   // Snapshot order: {ready, halt, done, icache_flush, flush, inval, timeout}
   localparam logic [6:0] RDY  = 7'b1000000;
   localparam logic [6:0] HALT = 7'b0100000;
   localparam logic [6:0] DN   = 7'b0110000;
   localparam logic [6:0] IC   = 7'b0101000;
   localparam logic [6:0] FL   = 7'b0100100;
   localparam logic [6:0] IV   = 7'b0100010;
   localparam logic [6:0] TMO  = 7'b0000001;

   logic [6:0] obs_d, obs_p;
   assign obs_d = {if_d.fence_ready_o, if_d.halt_o, if_d.fence_done_o, if_d.icache_flush_o,
                   if_d.dcache_flush_o, if_d.dcache_inval_o, if_d.drain_timeout_o};
   assign obs_p = {if_p.fence_ready_o, if_p.halt_o, if_p.fence_done_o, if_p.icache_flush_o,
                   if_p.dcache_flush_o, if_p.dcache_inval_o, if_p.drain_timeout_o};

   bit         probe_at [0:4095];
   int         exp_cyc [$];
   logic [6:0] exp_vec [$];
   string      exp_name [$];

   function automatic void expect_at(input int c, input string n, input logic [6:0] v);
      probe_at[c] = 1'b1;
      exp_cyc.push_back(c);
      exp_vec.push_back(v);
      exp_name.push_back(n);
   endfunction

   // Monitor
   logic tmo_prev = 1'b0;
   always @(negedge clk) begin
      logic [6:0] obs;
      int         ec;
      logic [6:0] ev;
      string      en;
      obs = sel ? obs_p : obs_d;
      if (!rst && (probe_at[cyc] || (|obs[4:1]) || (obs[0] != tmo_prev))) begin
         checks++;
         if (exp_cyc.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output cyc=%0d got=%b want=none", cyc, obs);
         end else begin
            ec = exp_cyc.pop_front();
            ev = exp_vec.pop_front();
            en = exp_name.pop_front();
            if (ec != cyc || ev != obs) begin
               errors++;
               $display("FAIL %s got=%b@cyc%0d want=%b@cyc%0d", en, obs, cyc, ev, ec);
            end
         end
      end
      tmo_prev = obs[0];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset(input logic s);
      valid = 1'b0; kind = 1'b0; stbuf = 1'b1; wbuf = 1'b1;
      flush_ack = 1'b0; inval_ack = 1'b0;
      rst = 1'b1;
      sel = s;
      tick();
      tick();
      rst = 1'b0;
      expect_at(cyc, "reset_state", RDY);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      tick();

      // 1: plain FENCE, buffers empty, minimum latency
      do_reset(1'b0);
      t0 = cyc;
      expect_at(t0,     "t1_accept", RDY);
      expect_at(t0 + 1, "t1_drain",  HALT);
      expect_at(t0 + 2, "t1_done",   DN);
      expect_at(t0 + 3, "t1_idle",   RDY);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      wait_until(t0 + 4);

      // 2: FENCE.I, write buffer busy 5 cycles, flush ack after 3 cycles
      do_reset(1'b0);
      kind = 1'b1; wbuf = 1'b0;
      t0 = cyc;
      expect_at(t0,     "t2_accept", RDY);
      expect_at(t0 + 3, "t2_drain",  HALT);
      expect_at(t0 + 7, "t2_flush0", FL);
      expect_at(t0 + 8, "t2_flush1", FL);
      expect_at(t0 + 9, "t2_flush2", FL);
      expect_at(t0 + 10, "t2_icache", IC);
      expect_at(t0 + 11, "t2_done",  DN);
      expect_at(t0 + 12, "t2_idle",  RDY);
      valid = 1'b1;
      tick();
      valid = 1'b0; kind = 1'b0;
      tick();
      flush_ack = 1'b1;           // stray ack during drain
      tick();
      flush_ack = 1'b0;
      wait_until(t0 + 6);
      wbuf = 1'b1;
      wait_until(t0 + 9);
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      wait_until(t0 + 13);

      // 3: invalidate-on-flush instance, FENCE.I, immediate flush ack
      do_reset(1'b1);
      kind = 1'b1;
      t0 = cyc;
      expect_at(t0,     "t3_accept", RDY);
      expect_at(t0 + 1, "t3_drain",  HALT);
      expect_at(t0 + 2, "t3_flush",  FL);
      expect_at(t0 + 3, "t3_inval0", IV);
      expect_at(t0 + 4, "t3_inval1", IV);
      expect_at(t0 + 5, "t3_icache", IC);
      expect_at(t0 + 6, "t3_done",   DN);
      expect_at(t0 + 7, "t3_idle",   RDY);
      valid = 1'b1;
      tick();
      valid = 1'b0; kind = 1'b0;
      tick();
      flush_ack = 1'b1; inval_ack = 1'b1;
      tick();
      inval_ack = 1'b0;
      tick();
      flush_ack = 1'b0; inval_ack = 1'b1;
      tick();
      inval_ack = 1'b0;
      wait_until(t0 + 8);

      // 4: drain watchdog (DrainTimeout=8), store buffer busy 20 cycles
      do_reset(1'b1);
      stbuf = 1'b0;
      t0 = cyc;
      expect_at(t0,      "t4_accept",   RDY);
      expect_at(t0 + 7,  "t4_pre_tmo",  HALT);
      expect_at(t0 + 8,  "t4_tmo_rise", HALT | TMO);
      expect_at(t0 + 15, "t4_tmo_hold", HALT | TMO);
      expect_at(t0 + 22, "t4_done",     DN | TMO);
      expect_at(t0 + 23, "t4_idle_tmo", RDY | TMO);
      expect_at(t0 + 24, "t4_tmo_clr",  HALT);
      expect_at(t0 + 25, "t4_done2",    DN);
      expect_at(t0 + 26, "t4_idle2",    RDY);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      wait_until(t0 + 21);
      stbuf = 1'b1;
      wait_until(t0 + 23);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      wait_until(t0 + 27);

      // 5: reset while flushing, late ack afterwards
      do_reset(1'b0);
      kind = 1'b1;
      t0 = cyc;
      expect_at(t0,     "t5_accept",   RDY);
      expect_at(t0 + 2, "t5_flush",    FL);
      expect_at(t0 + 4, "t5_post_rst", RDY);
      expect_at(t0 + 5, "t5_late_ack", RDY);
      valid = 1'b1;
      tick();
      valid = 1'b0; kind = 1'b0;
      wait_until(t0 + 3);
      rst = 1'b1;
      tick();
      rst = 1'b0; flush_ack = 1'b1;
      tick();
      tick();
      flush_ack = 1'b0;
      wait_until(t0 + 7);

      // 6: fence_valid held high, back-to-back fences
      do_reset(1'b0);
      t0 = cyc;
      for (int k = 0; k < 3; k++) begin
         expect_at(t0 + 3 * k,     "t6_accept", RDY);
         expect_at(t0 + 3 * k + 1, "t6_drain",  HALT);
         expect_at(t0 + 3 * k + 2, "t6_done",   DN);
      end
      expect_at(t0 + 9,  "t6_idle0", RDY);
      expect_at(t0 + 10, "t6_idle1", RDY);
      valid = 1'b1;
      wait_until(t0 + 7);
      valid = 1'b0;
      wait_until(t0 + 12);

      checks++;
      if (exp_cyc.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations got=%0d want=0", exp_cyc.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
